// File: rtl/spi_master_tx.sv
// SPI mode-0 master, 8-bit MSB-first frames; all pins and status are registered off the FSM state.
// Accept edge t0 -> ss low from t0+1, done on t0+17*CLK_DIV+1; start is ignored while a frame is in flight.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic                fin_q, fin_d;
  logic                sclk_q, sclk_d;
  logic                ss_q, ss_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                div_end;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    fin_d      = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = div_end ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          tx_shift_d = tx_data;
          cnt_d      = '0;
          div_d      = '0;
        end
      end
      S_SETUP: begin
        if (div_end) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (div_end) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_LOW;
            cnt_d      = cnt_q + CNT_W'(1);
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_LOW: begin
        if (div_end) state_d = S_HIGH;
      end
      S_FINISH: begin
        if (div_end) begin
          state_d = S_IDLE;
          fin_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins lag the state by one edge, so miso is taken on the same edge that raises sclk.
    if (state_q == S_HIGH && div_q == '0) begin
      rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
    end

    sclk_d    = (state_q == S_HIGH);
    ss_d      = (state_q == S_IDLE);
    busy_d    = (state_q != S_IDLE);
    mosi_d    = (state_q == S_IDLE) ? 1'b0 : tx_shift_q[DATA_W-1];
    done_d    = fin_q;
    rx_data_d = fin_q ? rx_shift_q : rx_data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      fin_q      <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      fin_q      <= fin_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign sclk    = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: table of whole-frame vectors at CLK_DIV=4, plus
// mid-frame reset and back-to-back CLK_DIV=1 sequences.
module tb_spi_master_tx;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sclk, ss, mosi, miso;
  logic [7:0] rx_data;

  logic       start1;
  logic [7:0] tx_data1;
  logic       busy1, done1, sclk1, ss1, mosi1;
  logic [7:0] rx_data1;

  int         miso_mode;
  logic [7:0] sl_byte;
  logic [7:0] sl_rx;
  int         sl_idx;
  logic       sl_miso;

  int n_pass  = 0;
  int n_total = 0;

  spi_master_tx #(.CLK_DIV(4), .DATA_W(8)) u_dut (
    .clock(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master_tx #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
    .clock(clk), .reset_n(reset_n), .start(start1), .tx_data(tx_data1),
    .busy(busy1), .done(done1), .rx_data(rx_data1),
    .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(mosi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b0 :
                (miso_mode == 2) ? 1'b1 : sl_miso;

  // Mode-0 slave: first bit presented at ss fall, next bit after each sclk fall.
  initial begin
    sl_idx = 7;
    sl_rx  = 8'h00;
  end
  always @(negedge ss) begin
    sl_idx = 7;
    sl_rx  = 8'h00;
  end
  always @(negedge sclk) if (!ss) sl_idx = sl_idx - 1;
  always @(posedge sclk) if (!ss) sl_rx = {sl_rx[6:0], mosi};
  assign sl_miso = (sl_idx >= 0 && sl_idx <= 7) ? sl_byte[sl_idx[2:0]] : 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_frame(input logic [7:0] tx, input int poke,
                           output logic [7:0] bits, output int rises,
                           output int done_at, output int done_cnt,
                           output int busy_cnt, output int busy_first,
                           output int ss_low, output logic mosi_any);
    logic prev_sclk;
    bits = 8'h00; rises = 0; done_at = -1; done_cnt = 0;
    busy_cnt = 0; busy_first = -1; ss_low = 0; mosi_any = 1'b0; prev_sclk = 1'b0;
    @(negedge clk);
    start = 1'b1; tx_data = tx;
    @(negedge clk);
    start = 1'b0; tx_data = ~tx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (!ss) ss_low++;
      if (!ss && mosi) mosi_any = 1'b1;
      if (sclk && !prev_sclk) begin
        rises++;
        bits = {bits[6:0], mosi};
      end
      prev_sclk = sclk;
      if (k == poke) begin
        start = 1'b1; tx_data = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    int         mode;
    logic [7:0] sl_byte;
    int         poke;
    logic [7:0] exp_rx;
    logic [7:0] exp_sl;
  } vec_t;

  vec_t vecs[5];

  int dn_q[$];
  int rx_q[$];
  int lows[$];
  int highs[$];

  initial begin
    logic [7:0] bits;
    logic       mosi_any;
    int rises, done_at, done_cnt, busy_cnt, busy_first, ss_low;
    int r3, cnt_done, cnt_busy, run;
    logic prev_ss1;

    vecs[0] = '{8'hA5, 0, 8'h00, 0,  8'hA5, 8'h00};
    vecs[1] = '{8'h81, 3, 8'h3C, 0,  8'h3C, 8'h81};
    vecs[2] = '{8'h00, 2, 8'h00, 0,  8'hFF, 8'h00};
    vecs[3] = '{8'h00, 1, 8'h00, 0,  8'h00, 8'h00};
    vecs[4] = '{8'h5A, 0, 8'h00, 20, 8'h5A, 8'h00};

    reset_n = 1'b0; start = 1'b0; tx_data = 8'h00;
    start1 = 1'b0; tx_data1 = 8'h00;
    miso_mode = 0; sl_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_rx", rx_data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      miso_mode = vecs[i].mode;
      sl_byte   = vecs[i].sl_byte;
      run_frame(vecs[i].tx, vecs[i].poke, bits, rises, done_at, done_cnt,
                busy_cnt, busy_first, ss_low, mosi_any);
      check($sformatf("v%0d_rx", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_mosi_bits", i), bits, vecs[i].tx);
      check($sformatf("v%0d_sclk_rises", i), rises, 8);
      check($sformatf("v%0d_done_at", i), done_at, 69);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_busy_first", i), busy_first, 1);
      check($sformatf("v%0d_busy_cnt", i), busy_cnt, 68);
      check($sformatf("v%0d_ss_low", i), ss_low, 68);
      check($sformatf("v%0d_mosi_any", i), mosi_any, |vecs[i].tx);
      if (vecs[i].mode == 3) check($sformatf("v%0d_slave_rx", i), sl_rx, vecs[i].exp_sl);
    end

    // Reset after the third sclk rise must abort the frame cleanly.
    miso_mode = 2;
    @(negedge clk);
    start = 1'b1; tx_data = 8'h96;
    @(negedge clk);
    start = 1'b0;
    r3 = 0;
    for (int k = 0; k < 60 && r3 < 3; k++) begin
      logic ps;
      ps = sclk;
      @(negedge clk);
      if (sclk && !ps) r3++;
    end
    check("t5_third_rise", r3, 3);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_ss", ss, 1);
    check("t5_sclk", sclk, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_rx", rx_data, 0);
    cnt_done = 0; cnt_busy = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("t5_no_done", cnt_done, 0);
    check("t5_no_busy", cnt_busy, 0);
    miso_mode = 0;
    run_frame(8'h3C, 0, bits, rises, done_at, done_cnt, busy_cnt, busy_first, ss_low, mosi_any);
    check("t5_after_rx", rx_data, 8'h3C);
    check("t5_after_done_at", done_at, 69);

    // CLK_DIV=1 with start held: continuous frames.
    @(negedge clk);
    start1 = 1'b1; tx_data1 = 8'h6B;
    prev_ss1 = 1'b1; run = 0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (done1) begin
        dn_q.push_back(k);
        rx_q.push_back(int'(rx_data1));
      end
      if (ss1 != prev_ss1) begin
        if (!prev_ss1) lows.push_back(run);
        else if (dn_q.size() > 0) highs.push_back(run);
        run = 1;
      end else begin
        run++;
      end
      prev_ss1 = ss1;
    end
    start1 = 1'b0;
    check("t6_enough_dones", int'(dn_q.size() >= 4), 1);
    check("t6_enough_lows", int'(lows.size() >= 3), 1);
    check("t6_enough_highs", int'(highs.size() >= 2), 1);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < dn_q.size()) check($sformatf("t6_done_gap%0d", i), dn_q[i+1] - dn_q[i], 18);
      if (i < rx_q.size()) check($sformatf("t6_rx%0d", i), rx_q[i], 8'h6B);
      if (i < lows.size()) check($sformatf("t6_ss_low%0d", i), lows[i], 17);
      if (i < 2 && i < highs.size()) check($sformatf("t6_ss_high%0d", i), highs[i], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
